// File: rtl/serial_link_lane_deskew.sv
// Receive-side lane aligner: per-lane FIFOs absorb skew and release one aligned word once every lane holds data.
// Optional skew timeout with auto-flush is built only when SERIAL_LINK_DESKEW_TIMEOUT_EN is defined.
module serial_link_lane_deskew #(
    parameter int NumLanes      = 8,
    parameter int LaneWidth     = 8,
    parameter int Depth         = 8,
    parameter int SkewCntWidth  = 8,
    parameter int TimeoutCycles = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          clr_err_i,
    input  logic [NumLanes-1:0]           lane_valid_i,
    input  logic [NumLanes*LaneWidth-1:0] lane_data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NumLanes*LaneWidth-1:0] data_o,
    output logic [SkewCntWidth-1:0]       skew_max_o,
    output logic [NumLanes-1:0]           overflow_o,
    output logic                          timeout_o
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;

    logic [LaneWidth-1:0]    mem [NumLanes][Depth];
    logic [PW-1:0]           wr_ptr [NumLanes];
    logic [PW-1:0]           rd_ptr [NumLanes];
    logic [NumLanes-1:0]     empty;
    logic [NumLanes-1:0]     full;
    logic [NumLanes-1:0]     push;
    logic [NumLanes-1:0]     ovf_set;
    logic                    all_valid;
    logic                    partial;
    logic                    pop;
    logic                    flush_all;
    logic                    timeout_hit;
    logic [SkewCntWidth-1:0] skew_cnt;
    logic [SkewCntWidth-1:0] skew_max;
    logic [NumLanes-1:0]     overflow;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        for (int i = 0; i < NumLanes; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
    end

    assign all_valid = ~|empty;
    assign partial   = (|empty) && !(&empty);
    assign flush_all = flush_i | timeout_hit;
    assign pop       = all_valid & ready_i & ~flush_all;

    always_comb begin
        push    = '0;
        ovf_set = '0;
        for (int i = 0; i < NumLanes; i++) begin
            push[i]    = lane_valid_i[i] & (~full[i] | pop) & ~flush_all;
            ovf_set[i] = lane_valid_i[i] & full[i] & ~pop & ~flush_all;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumLanes; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else if (flush_all) begin
            for (int i = 0; i < NumLanes; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumLanes; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop)     rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // Storage is not reset; data_o is masked while any lane is empty.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumLanes; i++) begin
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= lane_data_i[i*LaneWidth +: LaneWidth];
        end
    end

    always_comb begin
        data_o = '0;
        if (all_valid) begin
            for (int i = 0; i < NumLanes; i++) begin
                data_o[i*LaneWidth +: LaneWidth] = mem[i][rd_ptr[i][AW-1:0]];
            end
        end
    end

    assign valid_o = all_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skew_cnt <= '0;
        end else if (flush_all || !partial) begin
            skew_cnt <= '0;
        end else if (skew_cnt != {SkewCntWidth{1'b1}}) begin
            skew_cnt <= skew_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skew_max <= '0;
            overflow <= '0;
        end else begin
            if (clr_err_i)                skew_max <= '0;
            else if (skew_cnt > skew_max) skew_max <= skew_cnt;
            // A fresh overflow in the clear cycle must survive the clear.
            if (clr_err_i) overflow <= ovf_set;
            else           overflow <= overflow | ovf_set;
        end
    end

    assign skew_max_o = skew_max;
    assign overflow_o = overflow;

`ifdef SERIAL_LINK_DESKEW_TIMEOUT_EN
    localparam logic [SkewCntWidth-1:0] TimeoutVal = SkewCntWidth'(TimeoutCycles);
    logic timeout_q;

    assign timeout_hit = (skew_cnt >= TimeoutVal);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          timeout_q <= 1'b0;
        else if (clr_err_i) timeout_q <= timeout_hit;
        else                timeout_q <= timeout_q | timeout_hit;
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TimeoutCycles != 0);
    assign timeout_hit        = 1'b0;
    assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_serial_link_lane_deskew.sv
// Scoreboard bench for serial_link_lane_deskew: queue-based lane model, directed plan plus random traffic.
module tb_serial_link_lane_deskew;
    localparam int NL = 8;
    localparam int LW = 8;
    localparam int D  = 8;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           clr_err;
    logic [NL-1:0]  lane_valid;
    logic [63:0]    lane_data;
    logic           valid_o;
    logic           ready;
    logic [63:0]    data_o;
    logic [7:0]     skew_max_o;
    logic [NL-1:0]  overflow_o;
    logic           timeout_o;

    always #5 clk = ~clk;

    serial_link_lane_deskew #(
        .NumLanes(NL), .LaneWidth(LW), .Depth(D), .SkewCntWidth(8), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .clr_err_i(clr_err),
        .lane_valid_i(lane_valid), .lane_data_i(lane_data),
        .valid_o(valid_o), .ready_i(ready), .data_o(data_o),
        .skew_max_o(skew_max_o), .overflow_o(overflow_o), .timeout_o(timeout_o)
    );

    // Reference model: one queue of words per lane, plus skew/sticky bookkeeping.
    logic [7:0]  lq [NL][$];
    logic [63:0] sb [$];
    int          m_cnt, m_max;
    logic [7:0]  m_ovf;
    logic        m_tout;
    logic        e_valid, e_tout, e_tfl;
    logic [7:0]  e_ovf, e_max;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid_o", 64'(valid_o), 64'(e_valid));
            chk("overflow_o", 64'(overflow_o), 64'(e_ovf));
            chk("skew_max_o", 64'(skew_max_o), 64'(e_max));
            chk("timeout_o", 64'(timeout_o), 64'(e_tout));
            if (valid_o && ready && !flush && !e_tfl) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_o: got %0h expected no word at %0t", data_o, $time);
                end else begin
                    chk("data_o", data_o, sb.pop_front());
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NL; i++) lq[i].delete();
        sb.delete();
        m_cnt = 0; m_max = 0; m_ovf = '0; m_tout = 1'b0;
    endtask

    task automatic cycle(input logic [7:0] lv, input logic [63:0] ld, input logic rdy,
                         input logic fl, input logic clr);
        bit          allne, anyne, tfl, fa;
        logic [63:0] w;
        logic [7:0]  oset;
        @(posedge clk);
        #1;
        lane_valid = lv; lane_data = ld; ready = rdy; flush = fl; clr_err = clr;
        allne = 1; anyne = 0; w = '0; oset = '0;
        for (int i = 0; i < NL; i++) begin
            if (lq[i].size() == 0) allne = 0;
            else anyne = 1;
        end
`ifdef SERIAL_LINK_DESKEW_TIMEOUT_EN
        tfl = (m_cnt >= TO);
`else
        tfl = 0;
`endif
        fa = fl || tfl;
        e_valid = allne; e_ovf = m_ovf; e_max = m_max[7:0]; e_tout = m_tout; e_tfl = tfl;
        mon_en = 1'b1;
        if (fa) begin
            for (int i = 0; i < NL; i++) lq[i].delete();
        end else begin
            if (allne && rdy) begin
                for (int i = 0; i < NL; i++) w[i*8 +: 8] = lq[i].pop_front();
                sb.push_back(w);
            end
            for (int i = 0; i < NL; i++) begin
                if (lv[i]) begin
                    if (lq[i].size() < D) lq[i].push_back(ld[i*8 +: 8]);
                    else oset[i] = 1'b1;
                end
            end
        end
        m_max = clr ? 0 : ((m_cnt > m_max) ? m_cnt : m_max);
        m_cnt = fa ? 0 : ((anyne && !allne) ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0);
        m_ovf = clr ? oset : (m_ovf | oset);
        m_tout = clr ? tfl : (m_tout | tfl);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) cycle(8'h00, 64'h0, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        lane_valid = '0; lane_data = '0; ready = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #1;
        chk("rst valid_o", 64'(valid_o), 64'h0);
        chk("rst data_o", data_o, 64'h0);
        chk("rst skew_max_o", 64'(skew_max_o), 64'h0);
        chk("rst overflow_o", 64'(overflow_o), 64'h0);
        chk("rst timeout_o", 64'(timeout_o), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  b0;
        rst = 1'b1;
        model_reset();
        do_reset();

        // All lanes aligned in one cycle.
        cycle(8'hFF, 64'h1716151413121110, 1'b1, 1'b0, 1'b0);
        chk("t1 valid before", 64'(valid_o), 64'h0);
        idle(1, 1'b1);
        chk("t1 valid", 64'(valid_o), 64'h1);
        chk("t1 data", data_o, 64'h1716151413121110);
        idle(1, 1'b1);
        chk("t1 valid after", 64'(valid_o), 64'h0);

        // Staggered lanes, one per cycle.
        for (int i = 0; i < NL; i++) begin
            d = 64'(8'hA0 + 8'(i)) << (8 * i);
            cycle(8'(1 << i), d, 1'b1, 1'b0, 1'b0);
            chk("t2 valid while skewed", 64'(valid_o), 64'h0);
        end
        idle(1, 1'b1);
        chk("t2 valid", 64'(valid_o), 64'h1);
        chk("t2 data", data_o, 64'hA7A6A5A4A3A2A1A0);
        idle(1, 1'b1);
        chk("t2 skew_max", 64'(skew_max_o), 64'h7);

        // Fill to Depth with no pops, then one extra word on lane 3.
        cycle(8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < D; j++) cycle(8'hFF, {8{8'h30 + 8'(j)}}, 1'b0, 1'b0, 1'b0);
        cycle(8'h08, {8{8'hEE}}, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("t3 overflow", 64'(overflow_o), 64'h08);
        cycle(8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("t3 first pop", data_o, {8{8'h30}});
        idle(D, 1'b1);
        chk("t3 drained", 64'(valid_o), 64'h0);
        cycle(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);

        // Full FIFOs with simultaneous push and pop across the pointer wrap.
        for (int j = 0; j < D; j++) cycle(8'hFF, {8{8'h40 + 8'(j)}}, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) cycle(8'hFF, {8{8'h50 + 8'(j)}}, 1'b1, 1'b0, 1'b0);
        idle(D + 1, 1'b1);
        chk("t4 no overflow", 64'(overflow_o), 64'h0);

        // Flush keeps skew_max; clr_err zeroes it.
        cycle(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
        cycle(8'h20, {8{8'h5A}}, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        cycle(8'h00, 64'h0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("t5 valid after flush", 64'(valid_o), 64'h0);
        chk("t5 skew_max kept", 64'(skew_max_o), 64'h2);
        cycle(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        chk("t5 skew_max cleared", 64'(skew_max_o), 64'h0);

        // Only lane 0 pushes, then a long wait.
        b0 = 8'($urandom);
        cycle(8'h01, {56'h0, b0}, 1'b1, 1'b0, 1'b0);
        idle(70, 1'b1);
        cycle(8'hFE, {{7{8'h77}}, 8'h00}, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
`ifdef SERIAL_LINK_DESKEW_TIMEOUT_EN
        chk("t6 timeout", 64'(timeout_o), 64'h1);
        chk("t6 lane0 flushed", 64'(valid_o), 64'h0);
`else
        chk("t6 timeout", 64'(timeout_o), 64'h0);
        chk("t6 lane0 kept", data_o, {{7{8'h77}}, b0});
`endif
        cycle(8'h00, 64'h0, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b1);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            int   r;
            logic [7:0] lv;
            r  = int'($urandom_range(0, 9));
            lv = (r <= 5) ? 8'hFF : ((r <= 7) ? 8'($urandom) : 8'h00);
            cycle(lv, {$urandom, $urandom}, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 99) == 0), ($urandom_range(0, 63) == 0));
        end
        cycle(8'h00, 64'h0, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of traffic, then a normal transfer.
        for (int j = 0; j < 3; j++) cycle(8'hFF, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        cycle(8'h10, 64'h0, 1'b0, 1'b0, 1'b0);
        do_reset();
        cycle(8'hFF, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
        chk("t8 data after reset", data_o, 64'h0123456789ABCDEF);
        idle(2, 1'b1);
        @(negedge clk);
        chk("scoreboard drained", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_link_lane_deskew.md
Name: serial_link_lane_deskew

Overview:
Receive-side lane aligner for the serial link PHY.
- Per-lane data arrives with independent, unknown channel latency (lane skew).
- Each lane is buffered in its own small FIFO; one aligned word, all lanes concatenated, is released once every lane holds data.
- Sits between the per-lane receivers and the link-layer deserialiser. Reports maximum observed skew and sticky overflow.

Parameters:
NumLanes, 8, number of physical lanes.
LaneWidth, 8, bits per lane word.
Depth, 8, per-lane FIFO entries; power of two, >= 2.
SkewCntWidth, 8, width of skew counters (saturating).
TimeoutCycles, 64, skew timeout threshold; used only with the optional feature.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous active-high reset.
flush_i  in  1  synchronous clear of all FIFOs and the running skew counter.
clr_err_i  in  1  synchronous clear of sticky flags and skew_max_o.
lane_valid_i  in  NumLanes  per-lane word strobe; no backpressure.
lane_data_i  in  NumLanes*LaneWidth  per-lane words; lane i occupies bits [i*LaneWidth +: LaneWidth].
valid_o  out  1  aligned word available.
ready_i  in  1  downstream accepts.
data_o  out  NumLanes*LaneWidth  aligned word, same lane packing as the input.
skew_max_o  out  SkewCntWidth  largest skew seen, in cycles.
overflow_o  out  NumLanes  sticky per-lane overflow.
timeout_o  out  1  sticky skew timeout; tied 0 without the optional feature.

Behaviour:
- Reset (async, rst_i=1):
  - All FIFOs empty; valid_o=0; data_o=0.
  - Skew counter=0; skew_max_o=0; overflow_o=0; timeout_o=0.
- Push: lane_valid_i[i]=1 writes lane_data_i lane i into FIFO i.
- No fall-through: a word pushed in cycle N can appear on data_o in cycle N+1 at the earliest.
- valid_o=1 iff every lane FIFO is non-empty.
  - data_o = head of each FIFO, concatenated with lane 0 in the LSBs.
  - valid_o depends only on FIFO state; it never depends on ready_i.
- Pop: on valid_o&ready_i, all FIFOs pop together in the same cycle. A lane is never popped alone.
- Full FIFO with push and pop in the same cycle: the push is accepted, occupancy stays at Depth, no overflow.
- Full FIFO with push and no pop:
  - the word is dropped;
  - overflow_o[i] is set and stays set until clr_err_i or reset;
  - FIFO contents are unchanged.
- Skew counter:
  - Increments by 1 each cycle in which at least one FIFO is non-empty and at least one is empty.
  - Returns to 0 in any cycle in which all FIFOs are empty or all are non-empty.
  - Saturates at 2^SkewCntWidth-1.
- skew_max_o is updated to the running counter value whenever that value exceeds it. Registered, one cycle behind the counter.
- flush_i:
  - Takes effect at the next edge: all FIFOs empty, skew counter 0, valid_o=0.
  - Pushes and pops in the flush cycle are discarded.
  - Sticky flags and skew_max_o are kept.
- clr_err_i: clears overflow_o, timeout_o and skew_max_o. If a new overflow occurs in the same cycle, the set wins.
- flush_i and clr_err_i together: both actions apply.
- Reset mid-operation: all state is lost immediately; no output glitches beyond the reset values.
- Pointer wrap-around: read and write pointers use log2(Depth)+1 bits, and full/empty is derived from the MSB compare.

Optional Feature:
- Macro SERIAL_LINK_DESKEW_TIMEOUT_EN.
- Defined:
  - When the skew counter reaches TimeoutCycles, the block performs an internal flush on the next edge, identical to flush_i.
  - timeout_o is set (sticky).
  - Recovers unaligned lanes after a lost word.
- Undefined: no timeout logic is built; timeout_o=0 constant; TimeoutCycles is ignored.

Test Plan:
- Lanes 0..7 pushed in the same cycle with 0x10+i, ready_i=1 -> valid_o=1 in the next cycle, data_o=0x1716151413121110, then valid_o=0.
- Lane i pushed at cycle i (i=0..7) with 0xA0+i -> valid_o stays 0 until one cycle after lane 7's push; skew_max_o=7; data_o=0xA7A6A5A4A3A2A1A0.
- ready_i=0; all lanes push 8 words each (Depth=8), then a 9th push on lane 3 -> overflow_o=0x08, other lanes no overflow; first pop returns word 0; the 9th word is never output.
- Full FIFOs, ready_i=1, pushes on all lanes in the same cycle -> no overflow; 16 consecutive words come out in order, covering pointer wrap.
- Lane 5 holds data, flush_i pulsed -> next cycle all FIFOs empty, valid_o=0, skew counter 0, skew_max_o unchanged; clr_err_i then zeroes it.
- With SERIAL_LINK_DESKEW_TIMEOUT_EN: only lane 0 pushes; after 64 cycles -> FIFOs flushed, timeout_o=1. Without the macro -> timeout_o=0 and lane 0's data is retained.
